// File: rtl/toggle_bank_arbiter.sv
// toggle_bank_arbiter: round-robin arbiter applying one masked hold/toggle/clear/set per grant to a toggle-cell bank.
// Optional TOGGLE_BANK_PARITY_EN adds a registered even-parity output of Q.
module toggle_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [2*NREQ-1:0]     op,
   input  logic [WIDTH*NREQ-1:0] mask,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       ack,
   output logic                  busy,
   output logic [WIDTH-1:0]      Q,
   output logic [WIDTH-1:0]      Q_bar
`ifdef TOGGLE_BANK_PARITY_EN
   ,
   output logic                  parity
`endif
);
   localparam int PW = $clog2(NREQ);
   typedef enum logic [1:0] {IDLE, GRANT, ACK} state_t;
   state_t state_q, state_d;
   logic [PW-1:0] ptr_q, ptr_d, win_q, win_d, win;
   logic [1:0] op_q, op_d, op_sel;
   logic [WIDTH-1:0] mask_q, mask_d, mask_sel, q_q, q_d;
   logic [NREQ-1:0] gnt_q, gnt_d, ack_q, ack_d;
   // Scan from the farthest slot back to ptr so the last hit is the nearest requester.
   always_comb begin
      win = ptr_q;
      for (int k = NREQ - 1; k >= 0; k--)
         if (req[PW'((int'(ptr_q) + k) % NREQ)]) win = PW'((int'(ptr_q) + k) % NREQ);
      op_sel = '0;
      mask_sel = '0;
      for (int i = 0; i < NREQ; i++)
         if (win == PW'(i)) begin
            op_sel = op[2*i +: 2];
            mask_sel = mask[WIDTH*i +: WIDTH];
         end
   end
   always_comb begin
      state_d = state_q;
      ptr_d = ptr_q;
      win_d = win_q;
      op_d = op_q;
      mask_d = mask_q;
      q_d = q_q;
      gnt_d = gnt_q;
      ack_d = ack_q;
      case (state_q)
         IDLE: if (|req) begin
            state_d = GRANT;
            win_d = win;
            op_d = op_sel;
            mask_d = mask_sel;
            gnt_d = NREQ'(1) << win;
         end
         GRANT: begin
            state_d = ACK;
            ack_d = gnt_q;
            q_d = op_q == 2'b01 ? q_q ^ mask_q :
                  op_q == 2'b10 ? q_q & ~mask_q :
                  op_q == 2'b11 ? q_q | mask_q : q_q;
         end
         ACK: begin
            state_d = IDLE;
            gnt_d = '0;
            ack_d = '0;
            ptr_d = (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q <= '0;
         win_q <= '0;
         op_q <= '0;
         mask_q <= '0;
         q_q <= '0;
         gnt_q <= '0;
         ack_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         win_q <= win_d;
         op_q <= op_d;
         mask_q <= mask_d;
         q_q <= q_d;
         gnt_q <= gnt_d;
         ack_q <= ack_d;
      end
   end
`ifdef TOGGLE_BANK_PARITY_EN
   logic parity_q;
   always_ff @(posedge clk) parity_q <= rst ? 1'b0 : ^q_d;
   assign parity = parity_q;
`endif
   assign gnt = gnt_q;
   assign ack = ack_q;
   assign busy = state_q != IDLE;
   assign Q = q_q;
   assign Q_bar = ~q_q;
endmodule
